if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have port `clk`: input, 1 bit, single clock, rising edge.
REQ-002 The module SHALL have port `rst`: input, 1 bit, reset; asynchronous, active-low (0 = reset).
REQ-003 The module SHALL have port `stall`: input, `StallBus` (6) bits; bit 0 = this stage held.
REQ-004 The module SHALL have port `br_bus`: input, `BR_WD` (33) bits, {br_e, br_addr[31:0]}, driven combinationally by the decode stage.
REQ-005 The module SHALL have port `if_to_id_bus`: output, `IF_TO_ID_WD` (33) bits, {ce, pc[31:0]}.
REQ-006 The module SHALL have port `inst_sram_en`: output, 1 bit, fetch enable.
REQ-007 The module SHALL have port `inst_sram_wen`: output, 4 bits, constant 4'b0000.
REQ-008 The module SHALL have port `inst_sram_addr`: output, 32 bits, fetch address.
REQ-009 The module SHALL have port `inst_sram_wdata`: output, 32 bits, constant 32'b0.
REQ-010 The module SHALL have port `fetch_adef`: output, 1 bit, misaligned-fetch flag (see Configuration).

Function
REQ-011 State SHALL be held in four registers:
- pc_reg (32 bits)
- ce_reg (1 bit)
- pend_v (1 bit)
- pend_addr (32 bits)
REQ-012 next_pc SHALL be selected by priority:
- pend_v → pend_addr
- else br_e → br_addr
- else pc_reg + 32'h4 (modulo 2^32; 0xFFFFFFFC wraps to 0x00000000)
REQ-013 When stall[0] = NoStop, each clock edge SHALL:
- load pc_reg ← next_pc
- set ce_reg ← 1
- clear pend_v
REQ-014 When stall[0] = Stop, pc_reg and ce_reg SHALL hold their values.
REQ-015 When stall[0] = Stop and br_e = 1, pend_addr SHALL load br_addr and pend_v SHALL set; a later br_e during the same stall overwrites pend_addr.
REQ-016 When stall[0] = NoStop and pend_v = 1, pend_addr SHALL win over a simultaneous br_e; that br_e is discarded.
REQ-017 The outputs SHALL be driven as follows:
- inst_sram_addr = pc_reg
- inst_sram_en = ce_reg (gated per REQ-024)
- if_to_id_bus = {ce_reg, pc_reg}
REQ-018 Instruction data SHALL return one cycle after the address, aligned with the decode stage's registered copy of if_to_id_bus.
REQ-019 Branch latency SHALL be: br_e asserted in cycle t with no stall → inst_sram_addr = br_addr in cycle t+1. The instruction at pc_reg during cycle t is the delay slot and SHALL be fetched normally.
REQ-020 During a stall, inst_sram_en SHALL stay asserted on the held address; re-reading the same address is permitted.

Reset
REQ-021 While rst = 0, the registers SHALL take these values asynchronously:
- pc_reg = 32'hBFBF_FFFC
- ce_reg = 0
- pend_v = 0
- pend_addr = 0
REQ-022 While rst = 0, the outputs SHALL be:
- if_to_id_bus = {1'b0, 32'hBFBF_FFFC}
- inst_sram_en = 0
- fetch_adef = 0
REQ-023 Reset release SHALL be sampled synchronously. The first NoStop edge after release SHALL yield pc_reg = 32'hBFC0_0000 with ce_reg = 1. A reset asserted mid-stall or with pend_v set SHALL discard the pending target.

Configuration
REQ-024 With macro `IF_ALIGN_CHECK_EN` defined, misalignment (pc_reg[1:0] ≠ 2'b00 with ce_reg = 1) SHALL:
- force inst_sram_en = 0
- force the ce field of if_to_id_bus to 0 (bubble)
- set fetch_adef = 1 for that cycle

Without `IF_ALIGN_CHECK_EN`, fetch_adef SHALL be tied 0 and no gating SHALL occur.

Structure
REQ-025 The shared defines header SHALL hold these constants:
- `IF_TO_ID_WD` = 33
- `BR_WD` = 33
- `StallBus` = 6
- `Stop` / `NoStop`
- reset PC 32'hBFBF_FFFC
REQ-026 No sub-module SHALL be instantiated; the pending-branch latch and PC mux are local logic.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
1. Reset sequence: reset, release with no stall → addr sequence BFC00000, BFC00004, BFC00008; ce = 1 from first edge.
2. Branch: br_e = 1, br_addr = BFC00100 in cycle t, no stall → addr = BFC00100 in t+1, then BFC00104.
3. Stall with branch: stall[0] = Stop for 3 cycles with br_e pulse to BFC00200 in the first → addr held; after release addr = BFC00200; pend_v cleared.
4. Pending wins: pend_v set (BFC00300), release with simultaneous br_e to BFC00400 → addr = BFC00300.
5. Reset mid-operation: reset asserted mid-stall with pend_v = 1 → outputs immediately at reset values; after release fetch restarts at BFC00000, pending target lost.
6. Alignment: br_addr = BFC00002 with `IF_ALIGN_CHECK_EN` → next cycle inst_sram_en = 0, fetch_adef = 1, bus ce = 0. Without the macro → en = 1, fetch_adef = 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared widths, stall encoding and reset PC for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

   localparam int IF_TO_ID_WD = 33;
   localparam int BR_WD       = 33;
   localparam int StallBus    = 6;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
   localparam logic [31:0] PC_STEP  = 32'h0000_0004;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage: PC register, branch redirect and a
//            one-entry pending-branch latch that survives stalls.
//            Optional misaligned-fetch check: define IF_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
   import if_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [StallBus-1:0]    stall,
   input  logic [BR_WD-1:0]       br_bus,
   output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
   output logic                   inst_sram_en,
   output logic [3:0]             inst_sram_wen,
   output logic [31:0]            inst_sram_addr,
   output logic [31:0]            inst_sram_wdata,
   output logic                   fetch_adef
);

   logic [31:0] r_pc_reg;
   logic        r_ce_reg;
   logic        r_pend_v;
   logic [31:0] r_pend_addr;

   logic        w_br_e;
   logic [31:0] w_br_addr;
   logic        w_hold;
   logic [31:0] w_next_pc;
   logic        w_misalign;

   assign w_br_e    = br_bus[32];
   assign w_br_addr = br_bus[31:0];
   assign w_hold    = (stall[0] == Stop);

   // A branch captured during a stall takes priority over any branch
   // presented on the release edge, which is dropped.
   always_comb begin
      w_next_pc = r_pc_reg + PC_STEP;
      if (r_pend_v) begin
         w_next_pc = r_pend_addr;
      end else if (w_br_e) begin
         w_next_pc = w_br_addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc_reg    <= RESET_PC;
         r_ce_reg    <= 1'b0;
         r_pend_v    <= 1'b0;
         r_pend_addr <= 32'h0;
      end else if (!w_hold) begin
         r_pc_reg <= w_next_pc;
         r_ce_reg <= 1'b1;
         r_pend_v <= 1'b0;
      end else if (w_br_e) begin
         r_pend_addr <= w_br_addr;
         r_pend_v    <= 1'b1;
      end
   end

`ifdef IF_ALIGN_CHECK_EN
   assign w_misalign = r_ce_reg & (r_pc_reg[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign fetch_adef      = w_misalign;
   assign inst_sram_en    = r_ce_reg & ~w_misalign;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_addr  = r_pc_reg;
   assign inst_sram_wdata = 32'h0;
   assign if_to_id_bus    = {r_ce_reg & ~w_misalign, r_pc_reg};

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: directed scenarios followed by
//            random stall/branch traffic against a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic [32:0] if_to_id_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        fetch_adef;

   int n_checks = 0;
   int n_fails  = 0;

   // Behavioural view of the fetch stage
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_have_target;
   logic [31:0] m_target;

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .br_bus         (br_bus),
      .if_to_id_bus   (if_to_id_bus),
      .inst_sram_en   (inst_sram_en),
      .inst_sram_wen  (inst_sram_wen),
      .inst_sram_addr (inst_sram_addr),
      .inst_sram_wdata(inst_sram_wdata),
      .fetch_adef     (fetch_adef)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc          = 32'hBFBF_FFFC;
      m_valid       = 1'b0;
      m_have_target = 1'b0;
      m_target      = 32'h0;
   endtask

   task automatic model_edge(input bit held, input bit be, input logic [31:0] ba);
      if (!held) begin
         if (m_have_target)  m_pc = m_target;
         else if (be)        m_pc = ba;
         else                m_pc = m_pc + 32'd4;
         m_valid       = 1'b1;
         m_have_target = 1'b0;
      end else if (be) begin
         m_target      = ba;
         m_have_target = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic bad;
`ifdef IF_ALIGN_CHECK_EN
      bad = m_valid && (m_pc % 4 != 0);
`else
      bad = 1'b0;
`endif
      chk({tag, ".addr"}, {32'h0, inst_sram_addr}, {32'h0, m_pc});
      chk({tag, ".en"},   {63'h0, inst_sram_en},   {63'h0, m_valid && !bad});
      chk({tag, ".bus"},  {31'h0, if_to_id_bus},   {31'h0, m_valid && !bad, m_pc});
      chk({tag, ".adef"}, {63'h0, fetch_adef},     {63'h0, bad});
   endtask

   // Drive one cycle's inputs just after an edge; check just after the next.
   task automatic step(input string tag, input bit held, input bit be, input logic [31:0] ba);
      stall  = {5'($urandom_range(0, 31)), held};
      br_bus = {be, ba};
      @(posedge clk);
      model_edge(held, be, ba);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      rst    = 1'b0;
      stall  = 6'h0;
      br_bus = 33'h0;
      model_reset();
      @(posedge clk);
      #1;
      check_outputs("reset");
      chk("reset.wen",   {60'h0, inst_sram_wen},   64'h0);
      chk("reset.wdata", {32'h0, inst_sram_wdata}, 64'h0);

      // Sequential fetch from reset
      rst = 1'b1;
      step("seq0", 1'b0, 1'b0, 32'h0);
      chk("seq0.first", {32'h0, inst_sram_addr}, 64'hBFC0_0000);
      step("seq1", 1'b0, 1'b0, 32'h0);
      step("seq2", 1'b0, 1'b0, 32'h0);
      chk("seq2.third", {32'h0, inst_sram_addr}, 64'hBFC0_0008);

      // Branch redirect
      step("br0", 1'b0, 1'b1, 32'hBFC0_0100);
      chk("br0.tgt", {32'h0, inst_sram_addr}, 64'hBFC0_0100);
      step("br1", 1'b0, 1'b0, 32'h0);
      chk("br1.next", {32'h0, inst_sram_addr}, 64'hBFC0_0104);

      // Stall with branch pulse in its first cycle
      step("stb0", 1'b1, 1'b1, 32'hBFC0_0200);
      step("stb1", 1'b1, 1'b0, 32'h0);
      step("stb2", 1'b1, 1'b0, 32'h0);
      chk("stb2.held", {32'h0, inst_sram_addr}, 64'hBFC0_0104);
      step("stb3", 1'b0, 1'b0, 32'h0);
      chk("stb3.tgt", {32'h0, inst_sram_addr}, 64'hBFC0_0200);
      step("stb4", 1'b0, 1'b0, 32'h0);
      chk("stb4.cleared", {32'h0, inst_sram_addr}, 64'hBFC0_0204);

      // Pending target beats a branch on the release edge
      step("pw0", 1'b1, 1'b1, 32'hBFC0_0300);
      step("pw1", 1'b0, 1'b1, 32'hBFC0_0400);
      chk("pw1.pend", {32'h0, inst_sram_addr}, 64'hBFC0_0300);

      // Asynchronous reset mid-stall with a target pending
      step("rm0", 1'b1, 1'b1, 32'hBFC0_0500);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check_outputs("rm.async");
      @(posedge clk);
      #1;
      rst = 1'b1;
      step("rm1", 1'b0, 1'b0, 32'h0);
      chk("rm1.restart", {32'h0, inst_sram_addr}, 64'hBFC0_0000);
      step("rm2", 1'b0, 1'b0, 32'h0);

      // Misaligned branch target
      step("al0", 1'b0, 1'b1, 32'hBFC0_0002);
`ifdef IF_ALIGN_CHECK_EN
      chk("al0.adef", {63'h0, fetch_adef},   64'h1);
      chk("al0.en",   {63'h0, inst_sram_en}, 64'h0);
`else
      chk("al0.adef", {63'h0, fetch_adef},   64'h0);
      chk("al0.en",   {63'h0, inst_sram_en}, 64'h1);
`endif
      step("al1", 1'b0, 1'b1, 32'hBFC0_1000);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = $urandom();
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         step("rnd", ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), a);
         if ($urandom_range(0, 99) == 0) begin
            #1;
            rst = 1'b0;
            model_reset();
            #1;
            check_outputs("rnd.rst");
            @(posedge clk);
            #1;
            rst = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_if_stage
`default_nettype wire
